// File: rtl/sid_wave_table_sequencer_pkg.sv
// Shared constants and types for the multi-voice combined-waveform lookup sequencer.
// Default index/data widths match the SID oscillator and the _ST/P_T/PS_/PST ROM.
package sid_wave_table_sequencer_pkg;

  localparam int DEF_ACC_W  = 12;
  localparam int DEF_DATA_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] st;
    logic [DEF_DATA_W-1:0] pt;
    logic [DEF_DATA_W-1:0] ps;
    logic [DEF_DATA_W-1:0] pst;
  } wave_t;

endpackage

// File: rtl/sid_wave_table_sequencer_if.sv
// Bus to the shared waveform table: registered lookup indices out, four table outputs back.
// The table side has a fixed latency and no backpressure.
interface sid_wave_table_sequencer_if
  import sid_wave_table_sequencer_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ACC_W-1:0]  tbl_acc_ps;
  logic [ACC_W-1:0]  tbl_acc_t;
  logic [DATA_W-1:0] tbl_st_in;
  logic [DATA_W-1:0] tbl_pt_in;
  logic [DATA_W-1:0] tbl_ps_in;
  logic [DATA_W-1:0] tbl_pst_in;

  modport master (
    output tbl_acc_ps, tbl_acc_t,
    input  tbl_st_in, tbl_pt_in, tbl_ps_in, tbl_pst_in
  );

  modport slave (
    input  tbl_acc_ps, tbl_acc_t,
    output tbl_st_in, tbl_pt_in, tbl_ps_in, tbl_pst_in
  );
endinterface

// File: rtl/sid_wave_table_sequencer_capture_pipe.sv
// Tags table data with the voice it belongs to: a DEPTH-stage valid/index delay line.
// Latency DEPTH clk; flush drops every in-flight tag (sweep abort), no backpressure.
module sid_wave_table_sequencer_capture_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_sr;
  logic [IDX_W-1:0] idx_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) idx_sr[i] <= '0;
    end else begin
      idx_sr[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) idx_sr[i] <= idx_sr[i-1];
    end
  end

  assign out_vld = vld_sr[DEPTH-1];
  assign out_idx = idx_sr[DEPTH-1];

endmodule

// File: rtl/sid_wave_table_sequencer.sv
// Shares one combined-waveform ROM across NUM_VOICES oscillators: snapshot on ce_1m, one lookup per clk.
// Sweep takes NUM_VOICES+TABLE_LAT+1 clk; a ce_1m during a sweep aborts it, flags overrun and restarts.
module sid_wave_table_sequencer
  import sid_wave_table_sequencer_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TABLE_LAT  = 2,
  parameter int ATOMIC     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce_1m,
  input  logic [NUM_VOICES*ACC_W-1:0]  acc_ps_in,
  input  logic [NUM_VOICES*ACC_W-1:0]  acc_t_in,
  sid_wave_table_sequencer_if.master   tbl,
  output logic [NUM_VOICES*DATA_W-1:0] st_out,
  output logic [NUM_VOICES*DATA_W-1:0] pt_out,
  output logic [NUM_VOICES*DATA_W-1:0] ps_out,
  output logic [NUM_VOICES*DATA_W-1:0] pst_out,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int CNT_W = $clog2(NUM_VOICES + TABLE_LAT + 1);
  localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(NUM_VOICES + TABLE_LAT);
  localparam logic [CNT_W-1:0] NV_C    = CNT_W'(NUM_VOICES);
  localparam logic [CNT_W-1:0] NV_LAST = CNT_W'(NUM_VOICES - 1);
  localparam logic [VI_W-1:0]  VI_LAST = VI_W'(NUM_VOICES - 1);

  logic [0:0]                   state;
  logic [CNT_W-1:0]             cyc;
  logic [NUM_VOICES*ACC_W-1:0]  snap_ps, snap_t;
  logic [NUM_VOICES*DATA_W-1:0] stg_st, stg_pt, stg_ps, stg_pst;
  logic [NUM_VOICES*DATA_W-1:0] cap_st, cap_pt, cap_ps, cap_pst;
  logic                         issue_vld, cap_vld, last_cap;
  logic [VI_W-1:0]              cap_idx, nxt_idx;

  // cyc counts from 0 in the first issue cycle; voice k is on the table bus while cyc == k
  assign issue_vld = (state == ST_SWEEP) && (cyc < NV_C);
  assign nxt_idx   = VI_W'(cyc) + 1'b1;
  assign last_cap  = (state == ST_SWEEP) && cap_vld && (cap_idx == VI_LAST);

  sid_wave_table_sequencer_capture_pipe #(
    .DEPTH (TABLE_LAT),
    .IDX_W (VI_W)
  ) u_capture_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (ce_1m),
    .in_vld  (issue_vld),
    .in_idx  (VI_W'(cyc)),
    .out_vld (cap_vld),
    .out_idx (cap_idx)
  );

  // Result vectors with this cycle's table data merged in; the last voice's data is
  // folded in here so the atomic commit can happen on the same edge as its capture.
  always_comb begin
    cap_st  = (ATOMIC != 0) ? stg_st  : st_out;
    cap_pt  = (ATOMIC != 0) ? stg_pt  : pt_out;
    cap_ps  = (ATOMIC != 0) ? stg_ps  : ps_out;
    cap_pst = (ATOMIC != 0) ? stg_pst : pst_out;
    if ((state == ST_SWEEP) && cap_vld) begin
      cap_st [cap_idx*DATA_W +: DATA_W] = tbl.tbl_st_in;
      cap_pt [cap_idx*DATA_W +: DATA_W] = tbl.tbl_pt_in;
      cap_ps [cap_idx*DATA_W +: DATA_W] = tbl.tbl_ps_in;
      cap_pst[cap_idx*DATA_W +: DATA_W] = tbl.tbl_pst_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cyc            <= '0;
      snap_ps        <= '0;
      snap_t         <= '0;
      stg_st         <= '0;
      stg_pt         <= '0;
      stg_ps         <= '0;
      stg_pst        <= '0;
      st_out         <= '0;
      pt_out         <= '0;
      ps_out         <= '0;
      pst_out        <= '0;
      tbl.tbl_acc_ps <= '0;
      tbl.tbl_acc_t  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (ce_1m) begin
        // A tick mid-sweep drops that sweep entirely, including any capture due this edge.
        overrun        <= (state == ST_SWEEP);
        state          <= ST_SWEEP;
        busy           <= 1'b1;
        cyc            <= '0;
        snap_ps        <= acc_ps_in;
        snap_t         <= acc_t_in;
        tbl.tbl_acc_ps <= acc_ps_in[ACC_W-1:0];
        tbl.tbl_acc_t  <= acc_t_in[ACC_W-1:0];
      end else if (state == ST_SWEEP) begin
        if (cyc != CYC_MAX) cyc <= cyc + 1'b1;
        if (cyc < NV_LAST) begin
          tbl.tbl_acc_ps <= snap_ps[nxt_idx*ACC_W +: ACC_W];
          tbl.tbl_acc_t  <= snap_t[nxt_idx*ACC_W +: ACC_W];
        end
        if (ATOMIC != 0) begin
          stg_st  <= cap_st;
          stg_pt  <= cap_pt;
          stg_ps  <= cap_ps;
          stg_pst <= cap_pst;
        end
        if ((ATOMIC == 0) || last_cap) begin
          st_out  <= cap_st;
          pt_out  <= cap_pt;
          ps_out  <= cap_ps;
          pst_out <= cap_pst;
        end
        if (last_cap) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
